dram_write_arbiter: RTL and testbench

- Shares the single DRAM_Controller write-command port between two requesters.
- Port 0 is the camera BufferGearBox frame writer; port 1 is a secondary writer (result/metadata DMA).
- Round-robin arbitration at burst granularity, with per-port address-window protection and per-port grant counters for status.
- Sits between the requesters and DRAM_Controller (dram_write_addr/len/en/data/busy) in the m_axi_aclk domain.

---
 rtl/dram_write_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_dram_write_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_write_arbiter.sv
// Two-port write-command arbiter in front of the DRAM controller.
// Port 0 (frame writer) and port 1 (result/metadata DMA) share one command
// port. Arbitration is round-robin per burst. Each port may only write
// inside its own address window, and per-port grant/error counters are
// exported for status.
module dram_write_arbiter #(
    parameter int                    ADDR_WIDTH = 39,
    parameter int                    DATA_WIDTH = 512,
    parameter logic [ADDR_WIDTH-1:0] P0_BASE    = 39'h0_0000_0000,
    parameter logic [ADDR_WIDTH-1:0] P0_LIMIT   = 39'h0_3FFF_FFFF,
    parameter logic [ADDR_WIDTH-1:0] P1_BASE    = 39'h0_4000_0000,
    parameter logic [ADDR_WIDTH-1:0] P1_LIMIT   = 39'h0_7FFF_FFFF,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [7:0]            len0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  gnt0,
    output logic                  err0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [7:0]            len1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt1,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] dram_write_addr,
    output logic [7:0]            dram_write_len,
    output logic [DATA_WIDTH-1:0] dram_write_data,
    output logic                  dram_write_en,
    input  logic                  dram_write_busy,
    output logic [CNT_WIDTH-1:0]  gnt_cnt0,
    output logic [CNT_WIDTH-1:0]  gnt_cnt1,
    output logic [CNT_WIDTH-1:0]  err_cnt0,
    output logic [CNT_WIDTH-1:0]  err_cnt1,
    output logic                  last_grant
);

    localparam int                   BEAT_BYTES = DATA_WIDTH / 8;
    localparam int                   EW         = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Legal iff the whole burst [addr, addr+bytes-1] lies inside [base, limit].
    // The end address carries one extra bit so a wrap past the top is caught.
    function automatic logic window_ok(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] limit
    );
        logic [EW-1:0] beats;
        logic [EW-1:0] bytes;
        logic [EW-1:0] last;
        beats     = {{(EW-8){1'b0}}, len} + {{(EW-1){1'b0}}, 1'b1};
        bytes     = beats * EW'(BEAT_BYTES);
        last      = {1'b0, addr} + bytes - {{(EW-1){1'b0}}, 1'b1};
        window_ok = (addr >= base) && !last[EW-1] && (last[ADDR_WIDTH-1:0] <= limit);
    endfunction

    state_t                state_q, state_d;
    logic                  en_q, en_d;
    logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d;
    logic [CNT_WIDTH-1:0]  err_cnt0_q, err_cnt0_d, err_cnt1_q, err_cnt1_d;
    logic                  prio_q, prio_d;
    logic                  last_grant_q, last_grant_d;

    logic                  v0_s, v1_s, any_s, cand_s, cand_ok_s;

    // Candidate selection. A port whose error pulse is showing this cycle is
    // masked so the requester's trailing req cycle is not reported twice.
    always_comb begin
        v0_s  = req0 & ~err0_q;
        v1_s  = req1 & ~err1_q;
        any_s = v0_s | v1_s;
        if (v0_s && v1_s) begin
            cand_s = ~prio_q;
        end else if (v1_s) begin
            cand_s = 1'b1;
        end else begin
            cand_s = 1'b0;
        end
        if (cand_s) begin
            cand_ok_s = window_ok(addr1, len1, P1_BASE, P1_LIMIT);
        end else begin
            cand_ok_s = window_ok(addr0, len0, P0_BASE, P0_LIMIT);
        end
    end

    // Next-state and registered-output computation for the arbiter FSM.
    // WAIT exits straight through the arbiter so back-to-back bursts on an
    // idle controller are three cycles apart.
    always_comb begin
        state_d      = state_q;
        en_d         = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        addr_d       = addr_q;
        len_d        = len_q;
        data_d       = data_q;
        gnt_cnt0_d   = gnt_cnt0_q;
        gnt_cnt1_d   = gnt_cnt1_q;
        err_cnt0_d   = err_cnt0_q;
        err_cnt1_d   = err_cnt1_q;
        prio_d       = prio_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if ((state_q == ST_WAIT) && dram_write_busy) begin
                    state_d = ST_WAIT;
                end else if (!any_s) begin
                    state_d = ST_IDLE;
                end else if (!cand_ok_s) begin
                    state_d = ST_IDLE;
                    if (cand_s) begin
                        err1_d     = 1'b1;
                        err_cnt1_d = err_cnt1_q + CNT_ONE;
                    end else begin
                        err0_d     = 1'b1;
                        err_cnt0_d = err_cnt0_q + CNT_ONE;
                    end
                end else if (dram_write_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_ISSUE;
                    en_d         = 1'b1;
                    prio_d       = cand_s;
                    last_grant_d = cand_s;
                    if (cand_s) begin
                        gnt1_d     = 1'b1;
                        addr_d     = addr1;
                        len_d      = len1;
                        data_d     = data1;
                        gnt_cnt1_d = gnt_cnt1_q + CNT_ONE;
                    end else begin
                        gnt0_d     = 1'b1;
                        addr_d     = addr0;
                        len_d      = len0;
                        data_d     = data0;
                        gnt_cnt0_d = gnt_cnt0_q + CNT_ONE;
                    end
                end
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_WAIT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and output registers; port 0 holds priority out of reset.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q      <= ST_IDLE;
            en_q         <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            len_q        <= 8'd0;
            data_q       <= {DATA_WIDTH{1'b0}};
            gnt_cnt0_q   <= {CNT_WIDTH{1'b0}};
            gnt_cnt1_q   <= {CNT_WIDTH{1'b0}};
            err_cnt0_q   <= {CNT_WIDTH{1'b0}};
            err_cnt1_q   <= {CNT_WIDTH{1'b0}};
            prio_q       <= 1'b1;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            data_q       <= data_d;
            gnt_cnt0_q   <= gnt_cnt0_d;
            gnt_cnt1_q   <= gnt_cnt1_d;
            err_cnt0_q   <= err_cnt0_d;
            err_cnt1_q   <= err_cnt1_d;
            prio_q       <= prio_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt0            = gnt0_q;
    assign gnt1            = gnt1_q;
    assign err0            = err0_q;
    assign err1            = err1_q;
    assign dram_write_en   = en_q;
    assign dram_write_addr = addr_q;
    assign dram_write_len  = len_q;
    assign dram_write_data = data_q;
    assign gnt_cnt0        = gnt_cnt0_q;
    assign gnt_cnt1        = gnt_cnt1_q;
    assign err_cnt0        = err_cnt0_q;
    assign err_cnt1        = err_cnt1_q;
    assign last_grant      = last_grant_q;

endmodule

// File: tb/tb_dram_write_arbiter.sv
// Scoreboard bench for dram_write_arbiter: directed requests push expected
// grant/error events; a monitor pops and compares each DUT event.
module tb_dram_write_arbiter;

    localparam int AW = 39;
    localparam int DW = 512;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0]    len0, len1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, err0, err1;
    logic [AW-1:0] dram_write_addr;
    logic [7:0]    dram_write_len;
    logic [DW-1:0] dram_write_data;
    logic          dram_write_en;
    logic          dram_write_busy;
    logic [CW-1:0] gnt_cnt0, gnt_cnt1, err_cnt0, err_cnt1;
    logic          last_grant;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Controller model: busy for busy_len cycles starting the cycle after en.
    int   busy_len   = 0;
    int   pend       = 0;
    logic busy_m     = 1'b0;
    logic force_busy = 1'b0;
    assign dram_write_busy = force_busy | busy_m;

    typedef struct {
        bit            is_err;
        bit            port;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [DW-1:0] data;
        logic [CW-1:0] g0, g1, e0, e1;
        bit            lg;
        int            cyc;
    } exp_t;

    exp_t sbq[$];

    // Reference counters for the expected events.
    logic [CW-1:0] mg0 = 32'd0, mg1 = 32'd0, me0 = 32'd0, me1 = 32'd0;
    bit            mlg = 1'b0;

    bit            f_port[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] f_addr[6] = '{39'h0_3FFF_FF80, 39'h0_3FFF_FFC0, 39'h0_7FFF_FF00,
                                 39'h0_3FFF_FFC0, 39'h7F_FFFF_FFC0, 39'h0_3FFF_FFC0};
    logic [7:0]    f_len[6]  = '{8'd1, 8'd1, 8'd3, 8'd0, 8'd1, 8'd0};
    bit            f_ok[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    dram_write_arbiter dut (
        .m_axi_aclk      (clk),
        .m_axi_aresetn   (rst_n),
        .req0            (req0),
        .addr0           (addr0),
        .len0            (len0),
        .data0           (data0),
        .gnt0            (gnt0),
        .err0            (err0),
        .req1            (req1),
        .addr1           (addr1),
        .len1            (len1),
        .data1           (data1),
        .gnt1            (gnt1),
        .err1            (err1),
        .dram_write_addr (dram_write_addr),
        .dram_write_len  (dram_write_len),
        .dram_write_data (dram_write_data),
        .dram_write_en   (dram_write_en),
        .dram_write_busy (dram_write_busy),
        .gnt_cnt0        (gnt_cnt0),
        .gnt_cnt1        (gnt_cnt1),
        .err_cnt0        (err_cnt0),
        .err_cnt1        (err_cnt1),
        .last_grant      (last_grant)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit is_err, input bit port, input logic [AW-1:0] a,
                           input logic [7:0] l, input logic [DW-1:0] d, input int c);
        exp_t e;
        if (is_err) begin
            if (port) me1 = me1 + 32'd1;
            else      me0 = me0 + 32'd1;
        end else begin
            if (port) mg1 = mg1 + 32'd1;
            else      mg0 = mg0 + 32'd1;
            mlg = port;
        end
        e.is_err = is_err; e.port = port; e.addr = a; e.len = l; e.data = d;
        e.g0 = mg0; e.g1 = mg1; e.e0 = me0; e.e1 = me1; e.lg = mlg; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"},   DW'(dram_write_en), DW'(0));
        chk({tag, "_gnt"},  DW'({gnt1, gnt0}), DW'(0));
        chk({tag, "_err"},  DW'({err1, err0}), DW'(0));
        chk({tag, "_addr"}, DW'(dram_write_addr), DW'(0));
        chk({tag, "_len"},  DW'(dram_write_len), DW'(0));
        chk({tag, "_data"}, dram_write_data, DW'(0));
        chk({tag, "_gcnt"}, DW'({gnt_cnt1, gnt_cnt0}), DW'(0));
        chk({tag, "_ecnt"}, DW'({err_cnt1, err_cnt0}), DW'(0));
        chk({tag, "_lastg"}, DW'(last_grant), DW'(0));
    endtask

    // Drop each req once its gnt/err is seen; bounded.
    task automatic wait_release(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (gnt0 | err0) req0 = 1'b0;
            if (gnt1 | err1) req1 = 1'b0;
            if (!req0 && !req1) begin
                done = 1'b1;
                break;
            end
        end
        chk("req_released", DW'(done), DW'(1));
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pend > 0) begin
                busy_m = 1'b1;
                pend--;
            end else begin
                busy_m = 1'b0;
            end
            if (dram_write_en) pend = busy_len;
        end
    end

    // Monitor: every DUT event is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (dram_write_en | gnt0 | gnt1 | err0 | err1)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: cyc=%0d en=%b gnt=%b%b err=%b%b, expected no event",
                             cyc, dram_write_en, gnt1, gnt0, err1, err0);
                end else begin
                    e = sbq.pop_front();
                    chk("event_cycle", DW'(cyc), DW'(e.cyc));
                    if (!e.is_err) begin
                        chk("grant_en",   DW'(dram_write_en), DW'(1));
                        chk("grant_gnt",  DW'({gnt1, gnt0}), DW'(e.port ? 2'b10 : 2'b01));
                        chk("grant_err",  DW'({err1, err0}), DW'(0));
                        chk("grant_addr", DW'(dram_write_addr), DW'(e.addr));
                        chk("grant_len",  DW'(dram_write_len), DW'(e.len));
                        chk("grant_data", dram_write_data, e.data);
                    end else begin
                        chk("err_en",  DW'(dram_write_en), DW'(0));
                        chk("err_gnt", DW'({gnt1, gnt0}), DW'(0));
                        chk("err_err", DW'({err1, err0}), DW'(e.port ? 2'b10 : 2'b01));
                    end
                    chk("gnt_cnt0", DW'(gnt_cnt0), DW'(e.g0));
                    chk("gnt_cnt1", DW'(gnt_cnt1), DW'(e.g1));
                    chk("err_cnt0", DW'(err_cnt0), DW'(e.e0));
                    chk("err_cnt1", DW'(err_cnt1), DW'(e.e1));
                    chk("last_grant", DW'(last_grant), DW'(e.lg));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int en_seen;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = 8'd0; len1 = 8'd0; data0 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("reset");

        // Contention: both held, busy 4 cycles per burst -> 0,1,0,1 every 6 cycles.
        @(negedge clk);
        busy_len = 4;
        addr0 = 39'h0_0000_2000; len0 = 8'd1; data0 = {16{32'hA0A0_0001}};
        addr1 = 39'h0_4000_1000; len1 = 8'd2; data1 = {16{32'hB1B1_0002}};
        n = cyc;
        req0 = 1'b1; req1 = 1'b1;
        push_ev(1'b0, 1'b0, addr0, len0, data0, n + 1);
        push_ev(1'b0, 1'b1, addr1, len1, data1, n + 7);
        push_ev(1'b0, 1'b0, addr0, len0, data0, n + 13);
        push_ev(1'b0, 1'b1, addr1, len1, data1, n + 19);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) seen++;
            if (seen == 4) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("contention_grants", DW'(seen), DW'(4));
        repeat (8) @(negedge clk);
        chk("contention_gnt_cnt0", DW'(gnt_cnt0), DW'(2));
        chk("contention_gnt_cnt1", DW'(gnt_cnt1), DW'(2));

        // Reset asserted while waiting on a busy controller.
        busy_len = 6;
        addr1 = 39'h0_4000_2000; len1 = 8'd0; data1 = {16{32'hC2C2_0003}};
        n = cyc;
        req1 = 1'b1;
        push_ev(1'b0, 1'b1, addr1, len1, data1, n + 1);
        wait_release(20);
        repeat (3) @(negedge clk);
        chk("busy_in_wait", DW'(dram_write_busy), DW'(1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        force_busy = 1'b1;
        busy_len = 0;
        mg0 = 32'd0; mg1 = 32'd0; me0 = 32'd0; me1 = 32'd0; mlg = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        addr0 = 39'h0_0000_1000; len0 = 8'd0; data0 = {16{32'hD3D3_0004}};
        req0 = 1'b1;
        en_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (dram_write_en | gnt0) en_seen++;
        end
        chk("no_issue_while_busy", DW'(en_seen), DW'(0));
        n = cyc;
        force_busy = 1'b0;
        push_ev(1'b0, 1'b0, addr0, len0, data0, n + 1);
        wait_release(10);
        repeat (6) @(negedge clk);

        // Minimum spacing: req0 held for two bursts on an idle controller.
        addr0 = 39'h0_0000_1040; len0 = 8'd0; data0 = {16{32'hE4E4_0005}};
        n = cyc;
        req0 = 1'b1;
        push_ev(1'b0, 1'b0, addr0, len0, data0, n + 1);
        push_ev(1'b0, 1'b0, addr0, len0, data0, n + 4);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0) seen++;
            if (seen == 2) break;
        end
        req0 = 1'b0;
        chk("spacing_grants", DW'(seen), DW'(2));
        repeat (5) @(negedge clk);

        // Window violation on port 1 with a concurrent legal port-0 request.
        addr1 = 39'h0_0000_0100; len1 = 8'd0; data1 = {16{32'hF5F5_0006}};
        addr0 = 39'h0_0000_3000; len0 = 8'd0; data0 = {16{32'h1616_0007}};
        n = cyc;
        req0 = 1'b1; req1 = 1'b1;
        push_ev(1'b1, 1'b1, addr1, len1, data1, n + 1);
        push_ev(1'b0, 1'b0, addr0, len0, data0, n + 2);
        wait_release(20);
        repeat (5) @(negedge clk);

        // Window boundaries, one request at a time.
        for (int k = 0; k < 6; k++) begin
            n = cyc;
            if (f_port[k]) begin
                addr1 = f_addr[k]; len1 = f_len[k]; data1 = {16{32'h2700_0000 + 32'(k)}};
                req1 = 1'b1;
                push_ev(!f_ok[k], 1'b1, addr1, len1, data1, n + 1);
            end else begin
                addr0 = f_addr[k]; len0 = f_len[k]; data0 = {16{32'h3800_0000 + 32'(k)}};
                req0 = 1'b1;
                push_ev(!f_ok[k], 1'b0, addr0, len0, data0, n + 1);
            end
            wait_release(20);
            repeat (4) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", DW'(sbq.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
